// File: rtl/lsu_unit_if.sv
// lsu_unit_if: operator type plus the issue-side and data-memory-side bus of lsu_unit.
// slave modport is the LSU view; master modport is the issue stage / memory view.
package lsu_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LB  = 4'h1,
    OP_LH  = 4'h2,
    OP_LW  = 4'h3,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h6,
    OP_SH  = 4'h7,
    OP_SW  = 4'h8,
    OP_ADD = 4'h9
  } fu_op_t;
endpackage

interface lsu_unit_if;
  logic                lsu_valid_i;
  logic                lsu_ready_o;
  lsu_pkg::fu_op_t     lsu_operator_i;
  logic [31:0]         ls_addr_i;
  logic [31:0]         ls_store_data_i;
  logic                data_req_o;
  logic                data_gnt_i;
  logic                data_we_o;
  logic [3:0]          data_be_o;
  logic [31:0]         data_addr_o;
  logic [31:0]         data_wdata_o;
  logic                data_rvalid_i;
  logic [31:0]         data_rdata_i;
  logic                wb_valid_o;
  logic [31:0]         wb_data_o;
  logic                misalign_o;

  modport slave (
    input  lsu_valid_i, lsu_operator_i, ls_addr_i, ls_store_data_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output lsu_ready_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output wb_valid_o, wb_data_o, misalign_o
  );

  modport master (
    output lsu_valid_i, lsu_operator_i, ls_addr_i, ls_store_data_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  lsu_ready_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  wb_valid_o, wb_data_o, misalign_o
  );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit with byte-lane steering, load extension and a
// single-outstanding req/gnt/rvalid memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap
// instead of being silently forced to alignment).
//
// state  | meaning
// S_IDLE | ready for a new op
// S_REQ  | request on the bus, waiting for grant
// S_WAIT | granted, waiting for rvalid (or one-cycle trap slot)
module lsu_unit (
  input logic       clk_i,
  input logic       rst_i,
  lsu_unit_if.slave bus
);
  import lsu_pkg::*;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      r_state, w_next_state;
  logic        w_is_mem, w_is_load, w_uns, w_mis, w_trap, w_accept, w_done;
  logic [1:0]  w_size, w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic        r_is_load, r_uns, r_we, r_trap, r_wb_valid;
  logic [1:0]  r_size, r_off;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_wb_data;

  // Operator decode: size 0 = byte, 1 = half, 2 = word
  always_comb begin
    w_is_mem  = 1'b1;
    w_is_load = 1'b1;
    w_uns     = 1'b0;
    w_size    = 2'd0;
    case (bus.lsu_operator_i)
      OP_LB:  ;
      OP_LH:  w_size = 2'd1;
      OP_LW:  w_size = 2'd2;
      OP_LBU: w_uns = 1'b1;
      OP_LHU: begin w_size = 2'd1; w_uns = 1'b1; end
      OP_SB:  w_is_load = 1'b0;
      OP_SH:  begin w_size = 2'd1; w_is_load = 1'b0; end
      OP_SW:  begin w_size = 2'd2; w_is_load = 1'b0; end
      default: w_is_mem = 1'b0;
    endcase
  end

  assign w_mis = ((w_size == 2'd1) && (bus.ls_addr_i[1:0] == 2'b11)) ||
                 ((w_size == 2'd2) && (bus.ls_addr_i[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign w_accept = bus.lsu_valid_i && (r_state == S_IDLE) && w_is_mem;
  assign w_done   = (r_state == S_WAIT) && bus.data_rvalid_i && !r_trap;

  // Effective offset, lane enables and steered store data; misaligned accesses are forced aligned
  always_comb begin
    w_off = bus.ls_addr_i[1:0];
    if (w_mis) begin
      if (w_size == 2'd2) w_off = 2'b00;
      else                w_off = 2'b10;
    end
    case (w_size)
      2'd0:    begin w_be = 4'b0001 << w_off; w_wdata = {4{bus.ls_store_data_i[7:0]}};  end
      2'd1:    begin w_be = 4'b0011 << w_off; w_wdata = {2{bus.ls_store_data_i[15:0]}}; end
      default: begin w_be = 4'b1111;          w_wdata = bus.ls_store_data_i;            end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    case (r_off)
      2'd0:    begin w_byte = bus.data_rdata_i[7:0];   w_half = bus.data_rdata_i[15:0];  end
      2'd1:    begin w_byte = bus.data_rdata_i[15:8];  w_half = bus.data_rdata_i[23:8];  end
      2'd2:    begin w_byte = bus.data_rdata_i[23:16]; w_half = bus.data_rdata_i[31:16]; end
      default: begin w_byte = bus.data_rdata_i[31:24]; w_half = bus.data_rdata_i[31:16]; end
    endcase
    case (r_size)
      2'd0:    w_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = bus.data_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_trap ? S_WAIT : S_REQ;
      S_REQ:  if (bus.data_gnt_i) w_next_state = S_WAIT;
      S_WAIT: if (r_trap || bus.data_rvalid_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture the access on accept and produce the writeback / trap pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_is_load  <= 1'b0;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_off      <= 2'd0;
      r_be       <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_trap     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= 32'd0;
    end else begin
      r_trap     <= w_accept && w_trap;
      r_wb_valid <= w_done && r_is_load;
      if (w_done && r_is_load) r_wb_data <= w_ext;
      if (w_accept) begin
        r_is_load <= w_is_load;
        r_uns     <= w_uns;
        r_we      <= !w_is_load;
        r_size    <= w_size;
        r_off     <= w_off;
        r_be      <= w_be;
        r_addr    <= {bus.ls_addr_i[31:2], 2'b00};
        r_wdata   <= w_wdata;
      end
    end
  end

  // Output logic
  always_comb begin
    bus.lsu_ready_o  = (r_state == S_IDLE);
    bus.data_req_o   = (r_state == S_REQ);
    bus.data_we_o    = r_we;
    bus.data_be_o    = r_be;
    bus.data_addr_o  = r_addr;
    bus.data_wdata_o = r_wdata;
    bus.wb_valid_o   = r_wb_valid;
    bus.wb_data_o    = r_wb_data;
    bus.misalign_o   = r_trap;
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed table-driven bench for lsu_unit plus hand-written
// sequences for stalls, spurious responses, reset mid-op and misalignment.
module tb_lsu_unit;
  import lsu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   failures = 0;

  lsu_unit_if bus();

  lsu_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    fu_op_t      op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_bus(input string t, input vec_t v);
    chk({t, ".req"},   32'(bus.data_req_o), 32'd1);
    chk({t, ".addr"},  bus.data_addr_o, v.e_addr);
    chk({t, ".be"},    32'(bus.data_be_o), 32'(v.e_be));
    chk({t, ".we"},    32'(bus.data_we_o), 32'(v.e_we));
    chk({t, ".wdata"}, bus.data_wdata_o, v.e_wdata);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".ready_idle"}, 32'(bus.lsu_ready_o), 32'd1);
    bus.lsu_valid_i     = 1'b1;
    bus.lsu_operator_i  = v.op;
    bus.ls_addr_i       = v.addr;
    bus.ls_store_data_i = v.sdata;
    chk({t, ".req_not_comb"}, 32'(bus.data_req_o), 32'd0);
    cyc();
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_operator_i = OP_NOP;
    chk({t, ".ready_busy"}, 32'(bus.lsu_ready_o), 32'd0);
    chk({t, ".misalign"}, 32'(bus.misalign_o), 32'd0);
    chk_bus(t, v);
    for (int i = 0; i < v.gnt_dly; i++) begin
      cyc();
      chk_bus($sformatf("%s.stall%0d", t, i), v);
    end
    bus.data_gnt_i = 1'b1;
    cyc();
    bus.data_gnt_i = 1'b0;
    chk({t, ".req_wait"}, 32'(bus.data_req_o), 32'd0);
    chk({t, ".ready_wait"}, 32'(bus.lsu_ready_o), 32'd0);
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = v.rdata;
    cyc();
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'd0;
    chk({t, ".wb_valid"}, 32'(bus.wb_valid_o), 32'(!v.e_we));
    if (!v.e_we) chk({t, ".wb_data"}, bus.wb_data_o, v.e_wb);
    chk({t, ".ready_back"}, 32'(bus.lsu_ready_o), 32'd1);
    cyc();
    chk({t, ".wb_pulse_end"}, 32'(bus.wb_valid_o), 32'd0);
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, ".ready"},    32'(bus.lsu_ready_o), 32'd1);
    chk({t, ".req"},      32'(bus.data_req_o), 32'd0);
    chk({t, ".we"},       32'(bus.data_we_o), 32'd0);
    chk({t, ".be"},       32'(bus.data_be_o), 32'd0);
    chk({t, ".addr"},     bus.data_addr_o, 32'd0);
    chk({t, ".wdata"},    bus.data_wdata_o, 32'd0);
    chk({t, ".wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
    chk({t, ".wb_data"},  bus.wb_data_o, 32'd0);
    chk({t, ".misalign"}, 32'(bus.misalign_o), 32'd0);
  endtask

  initial begin
    bus.lsu_valid_i     = 1'b0;
    bus.lsu_operator_i  = OP_NOP;
    bus.ls_addr_i       = 32'd0;
    bus.ls_store_data_i = 32'd0;
    bus.data_gnt_i      = 1'b0;
    bus.data_rvalid_i   = 1'b0;
    bus.data_rdata_i    = 32'd0;

    //              op      addr          sdata         rdata         gnt e_addr        e_be     we    e_wdata       e_wb
    vecs.push_back('{OP_LW,  32'h1000_0004, 32'h0,        32'hDEAD_BEEF, 0, 32'h1000_0004, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF});
    vecs.push_back('{OP_LB,  32'h2000_0003, 32'h0,        32'h8000_0000, 0, 32'h2000_0000, 4'b1000, 1'b0, 32'h0,        32'hFFFF_FF80});
    vecs.push_back('{OP_LBU, 32'h2000_0003, 32'h0,        32'h8000_0000, 1, 32'h2000_0000, 4'b1000, 1'b0, 32'h0,        32'h0000_0080});
    vecs.push_back('{OP_LH,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001});
    vecs.push_back('{OP_LHU, 32'h0000_0200, 32'h0,        32'h1234_F00D, 0, 32'h0000_0200, 4'b0011, 1'b0, 32'h0,        32'h0000_F00D});
    vecs.push_back('{OP_LB,  32'h0000_0301, 32'h0,        32'h0000_7F00, 0, 32'h0000_0300, 4'b0010, 1'b0, 32'h0,        32'h0000_007F});
    vecs.push_back('{OP_SH,  32'h3000_0002, 32'h0000_1234, 32'h0,        3, 32'h3000_0000, 4'b1100, 1'b1, 32'h1234_1234, 32'h0});
    vecs.push_back('{OP_SB,  32'h3000_0001, 32'hAABB_CCDD, 32'h0,        0, 32'h3000_0000, 4'b0010, 1'b1, 32'hDDDD_DDDD, 32'h0});
    vecs.push_back('{OP_SW,  32'h3000_0008, 32'hCAFE_F00D, 32'h0,        2, 32'h3000_0008, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0});
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{OP_LW,  32'h1000_0001, 32'h0,        32'h1122_3344, 0, 32'h1000_0000, 4'b1111, 1'b0, 32'h0,        32'h1122_3344});
    vecs.push_back('{OP_LH,  32'h2000_0007, 32'h0,        32'hABCD_0000, 0, 32'h2000_0004, 4'b1100, 1'b0, 32'h0,        32'hFFFF_ABCD});
`endif

    #12;
    chk_reset_vals("reset");
    cyc();
    rst_i = 1'b0;
    cyc();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Spurious grant/response while idle
    bus.data_rvalid_i = 1'b1;
    bus.data_gnt_i    = 1'b1;
    bus.data_rdata_i  = 32'h7777_7777;
    cyc();
    bus.data_rvalid_i = 1'b0;
    bus.data_gnt_i    = 1'b0;
    chk("idle_rvalid.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("idle_rvalid.ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("idle_rvalid.req", 32'(bus.data_req_o), 32'd0);

    // Non-memory operator is not accepted
    bus.lsu_valid_i    = 1'b1;
    bus.lsu_operator_i = OP_ADD;
    cyc();
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_operator_i = OP_NOP;
    chk("nonmem.ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("nonmem.req", 32'(bus.data_req_o), 32'd0);

    // rvalid during REQ is ignored; response stall in WAIT
    bus.lsu_valid_i    = 1'b1;
    bus.lsu_operator_i = OP_LW;
    bus.ls_addr_i      = 32'h5000_0000;
    cyc();
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_operator_i = OP_NOP;
    bus.data_rvalid_i  = 1'b1;
    bus.data_rdata_i   = 32'h1111_1111;
    cyc();
    bus.data_rvalid_i  = 1'b0;
    chk("req_rvalid.req", 32'(bus.data_req_o), 32'd1);
    chk("req_rvalid.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    bus.data_gnt_i = 1'b1;
    cyc();
    bus.data_gnt_i = 1'b0;
    cyc();
    cyc();
    chk("rsp_stall.ready", 32'(bus.lsu_ready_o), 32'd0);
    chk("rsp_stall.req", 32'(bus.data_req_o), 32'd0);
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'h0BAD_F00D;
    cyc();
    bus.data_rvalid_i = 1'b0;
    chk("rsp_stall.wb_valid", 32'(bus.wb_valid_o), 32'd1);
    chk("rsp_stall.wb_data", bus.wb_data_o, 32'h0BAD_F00D);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word traps without a memory request
    cyc();
    bus.lsu_valid_i    = 1'b1;
    bus.lsu_operator_i = OP_LW;
    bus.ls_addr_i      = 32'h1000_0001;
    cyc();
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_operator_i = OP_NOP;
    chk("trap.misalign", 32'(bus.misalign_o), 32'd1);
    chk("trap.req", 32'(bus.data_req_o), 32'd0);
    chk("trap.ready_busy", 32'(bus.lsu_ready_o), 32'd0);
    cyc();
    chk("trap.misalign_end", 32'(bus.misalign_o), 32'd0);
    chk("trap.req2", 32'(bus.data_req_o), 32'd0);
    chk("trap.ready_back", 32'(bus.lsu_ready_o), 32'd1);
    chk("trap.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    cyc();
    chk("trap.wb_valid2", 32'(bus.wb_valid_o), 32'd0);
`endif

    // Reset asserted during WAIT, then a late response
    cyc();
    bus.lsu_valid_i    = 1'b1;
    bus.lsu_operator_i = OP_SW;
    bus.ls_addr_i      = 32'h4000_0010;
    bus.ls_store_data_i = 32'h1357_9BDF;
    cyc();
    bus.lsu_valid_i    = 1'b0;
    bus.lsu_operator_i = OP_NOP;
    bus.data_gnt_i     = 1'b1;
    cyc();
    bus.data_gnt_i     = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    cyc();
    rst_i = 1'b0;
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'h5555_AAAA;
    cyc();
    bus.data_rvalid_i = 1'b0;
    chk("late_rvalid.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("late_rvalid.ready", 32'(bus.lsu_ready_o), 32'd1);
    cyc();
    chk("late_rvalid.wb_valid2", 32'(bus.wb_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit directly downstream of the ALU. It accepts the operator, the computed effective address and the store data for LB/LH/LW/LBU/LHU/SB/SH/SW. It drives a single-outstanding request/grant/rvalid data-memory port and returns sign- or zero-extended load data to writeback. It performs byte-lane steering and alignment, so the ALU and the memory stay word-oriented.

## Interface
- No parameters; data/address width fixed at 32.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `lsu_valid_i` in 1: issue holds a memory op.
- `lsu_ready_o` out 1: LSU can accept; high only in IDLE.
- `lsu_operator_i` in fu_op_t: operator field of fu_data_t (LB..SW only; other values are ignored, no accept).
- `ls_addr_i` in 32: effective byte address (ALU `ls_addr_o`).
- `ls_store_data_i` in 32: store data, value in low bits (ALU `ls_store_data_o`).
- `data_req_o` out 1: memory request.
- `data_gnt_i` in 1: request accepted this cycle.
- `data_we_o` out 1: 1 = store.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `data_wdata_o` out 32: lane-steered store data.
- `data_rvalid_i` in 1: response valid; one per granted request, loads and stores alike.
- `data_rdata_i` in 32: load word.
- `wb_valid_o` out 1: one-cycle pulse, load result valid.
- `wb_data_o` out 32: extended load result.
- `misalign_o` out 1: one-cycle pulse, misaligned access (macro-dependent).

## Operation
**FSM states:** IDLE, REQ, WAIT.
- **IDLE → REQ:** on `lsu_valid_i && lsu_ready_o` with a memory operator. The unit registers the operator, `addr[1:0]`, byte enables, steered wdata and aligned address.
- **REQ:** `data_req_o` = 1, with addr/we/be/wdata held stable until `data_gnt_i`. Goes to WAIT on `data_gnt_i`.
- **WAIT:** `data_req_o` = 0. Returns to IDLE on `data_rvalid_i`.
  - Load: the result is registered and `wb_valid_o` pulses the next cycle.
  - Store: no writeback.

**Byte enables** (`off` = `addr[1:0]`):
- Byte access: `4'b0001 << off`.
- Half access: `4'b0011 << off`.
- Word access: `4'b1111`.

**Store data:**
- SB: byte replicated ×4.
- SH: half replicated ×2.
- SW: passed through.

**Load extract:**
- Byte: `rdata >> (8*off)`, bits [7:0].
- Half: `rdata >> (8*off)`, bits [15:0].
- LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word.

**Response handling:**
- `data_rvalid_i` in IDLE or REQ is ignored (no state change, no writeback).
- `data_gnt_i` outside REQ is ignored.

**Reset (asynchronous, any state):**
- State goes to IDLE and every output reads 0, except `lsu_ready_o`, which reads 1.
- A response arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Accept at edge N: `data_req_o` is high from cycle N+1 (registered output, not combinational from `lsu_valid_i`).
- With grant in cycle N+1 and `data_rvalid_i` in N+2: `wb_valid_o` and `wb_data_o` are valid in cycle N+3, for exactly one cycle.
- The load path therefore has a minimum latency of 3 cycles.
- `lsu_ready_o` is low from N+1 until the cycle after the rvalid edge, so a back-to-back op is accepted at the earliest in the cycle after rvalid.
- Grant stalls extend REQ indefinitely with the outputs stable.
- Response stalls extend WAIT indefinitely.
- `wb_data_o` holds its last value between pulses; it is meaningful only while `wb_valid_o` is high.

## Configuration
A misaligned access is a half access with `off == 3`, or a word access with `off != 0`.

**`LSU_MISALIGN_TRAP_EN` defined:**
- The access is accepted, but no memory request is issued.
- `misalign_o` pulses in cycle N+1; no `wb_valid_o`.
- FSM returns to IDLE at N+1 and `lsu_ready_o` is high again at N+2.

**`LSU_MISALIGN_TRAP_EN` undefined:**
- `misalign_o` is tied 0.
- The access proceeds with the address forced aligned: `off` is treated as 0 for word accesses and `off[0]` is cleared for half accesses.

## Test plan
- **LW with zero stalls:** LW at addr 0x1000_0004; gnt in N+1, rvalid in N+2 with rdata 0xDEAD_BEEF. Required: `data_addr_o` = 0x1000_0004, `data_be_o` = 4'b1111, `data_we_o` = 0, `wb_valid_o` at N+3 with `wb_data_o` = 0xDEAD_BEEF.
- **LB / LBU extension:** addr 0x...03, rdata 0x80_00_00_00. Required: LB returns 0xFFFF_FF80 and LBU returns 0x0000_0080.
- **SH with grant stall:** SH addr 0x...02, store data 0x0000_1234, gnt delayed 3 cycles. Required:
  - `data_be_o` = 4'b1100 and `data_wdata_o` = 0x1234_1234, held stable across the stall.
  - `data_we_o` = 1; no `wb_valid_o`; `lsu_ready_o` returns after rvalid.
- **Misaligned LW at 0x...01 with macro on:** `misalign_o` pulses at N+1, `data_req_o` stays 0, no writeback.
- **Misaligned LW at 0x...01 with macro off:** `data_addr_o` = 0x...00, `data_be_o` = 4'b1111, normal writeback.
- **Reset mid-operation and spurious response:** assert `rst_i` during WAIT, then drive a late rvalid. Required: all outputs 0 immediately, `lsu_ready_o` = 1, late rvalid produces no `wb_valid_o`. Separately, rvalid in IDLE with no op outstanding is ignored.
